// File: rtl/cpu_if_pkg.sv
// Shared types for the instruction-fetch stage.
// Fetch FSM states, bubble encoding and default reset PC.
package cpu_if_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } if_state_e;

    localparam logic [31:0] BUBBLE_INST  = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} skid buffer for the fetch stage.
// Clear wins over load, load wins over drain.
module if_skid_buf #(
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load,
    input  logic                 drain,
    input  logic                 clear,
    input  logic [ADDR_BITS-1:0] load_pc,
    input  logic [31:0]          load_inst,
    output logic                 valid,
    output logic [ADDR_BITS-1:0] pc,
    output logic [31:0]          inst
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            pc    <= '0;
            inst  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= load_pc;
            inst  <= load_inst;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// RV32 instruction-fetch stage: PC, single-outstanding fetch, IF/ID register.
// Optional IF_PERF_EN adds fetch/kill event counters.
module if_stage
    import cpu_if_pkg::*;
#(
    parameter int                   ADDR_BITS = 32,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = ADDR_BITS'(DEF_RESET_PC)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [ADDR_BITS-1:0] redirect_pc_i,
    output logic                 im_req_o,
    output logic [ADDR_BITS-1:0] im_addr_o,
    input  logic                 im_gnt_i,
    input  logic                 im_rvalid_i,
    input  logic [31:0]          im_rdata_i,
    output logic [ADDR_BITS-1:0] id_pc_o,
    output logic [31:0]          id_inst_o,
    output logic                 id_valid_o,
`ifdef IF_PERF_EN
    output logic                 if_wait_o,
    output logic [31:0]          perf_fetch_o,
    output logic [31:0]          perf_kill_o
`else
    output logic                 if_wait_o
`endif
);

    if_state_e            state;
    logic [ADDR_BITS-1:0] pc;
    logic [ADDR_BITS-1:0] fetch_pc;
    logic                 kill;

    logic                 take;
    logic                 accept;
    logic                 skid_load;
    logic                 skid_drain;
    logic                 skid_valid;
    logic [ADDR_BITS-1:0] skid_pc;
    logic [31:0]          skid_inst;

    assign take       = (state == S_WAIT) && im_rvalid_i;
    assign accept     = take && !kill && !redirect_i;
    assign skid_load  = accept && stall_i;
    assign skid_drain = (state == S_HOLD) && skid_valid
                        && !stall_i && !redirect_i;

    assign im_req_o  = (state == S_REQ);
    assign im_addr_o = {pc[ADDR_BITS-1:2], 2'b00};
    assign if_wait_o = (state == S_WAIT) && !im_rvalid_i;

    if_skid_buf #(
        .ADDR_BITS (ADDR_BITS)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .load      (skid_load),
        .drain     (skid_drain),
        .clear     (redirect_i),
        .load_pc   (fetch_pc),
        .load_inst (im_rdata_i),
        .valid     (skid_valid),
        .pc        (skid_pc),
        .inst      (skid_inst)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            fetch_pc   <= RESET_PC;
            kill       <= 1'b0;
            id_valid_o <= 1'b0;
            id_pc_o    <= RESET_PC;
            id_inst_o  <= BUBBLE_INST;
        end else if (redirect_i) begin
            pc         <= redirect_pc_i;
            id_valid_o <= 1'b0;
            id_inst_o  <= BUBBLE_INST;
            // A fetch still in flight must be drained before re-requesting
            if ((state == S_WAIT && !im_rvalid_i) ||
                (state == S_REQ && im_gnt_i)) begin
                kill  <= 1'b1;
                state <= S_WAIT;
            end else begin
                kill  <= 1'b0;
                state <= S_REQ;
            end
        end else begin
            unique case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (im_gnt_i) begin
                        fetch_pc <= pc;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (im_rvalid_i) begin
                        kill  <= 1'b0;
                        state <= (!kill && stall_i) ? S_HOLD : S_REQ;
                        if (!kill) pc <= fetch_pc + ADDR_BITS'(4);
                    end
                end
                S_HOLD: begin
                    if (!stall_i) state <= S_REQ;
                end
            endcase

            // Decode consumes IF/ID whenever it is not stalled
            if (accept && !stall_i) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= fetch_pc;
                id_inst_o  <= im_rdata_i;
            end else if (skid_drain) begin
                id_valid_o <= 1'b1;
                id_pc_o    <= skid_pc;
                id_inst_o  <= skid_inst;
            end else if (!stall_i) begin
                id_valid_o <= 1'b0;
                id_inst_o  <= BUBBLE_INST;
            end
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_fetch_o <= '0;
            perf_kill_o  <= '0;
        end else begin
            if (accept) perf_fetch_o <= perf_fetch_o + 32'd1;
            if (take && !accept) perf_kill_o <= perf_kill_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory responder, program-order
// model checked every cycle, plus directed literal checkpoints.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        im_gnt_i = 1'b1;
    logic        im_rvalid_i = 1'b0;
    logic [31:0] im_rdata_i = '0;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_valid_o;
    logic        if_wait_o;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_o;
    logic [31:0] perf_kill_o;
`endif

    if_stage dut (
        .clk           (clk),
        .rstn          (rstn),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .im_req_o      (im_req_o),
        .im_addr_o     (im_addr_o),
        .im_gnt_i      (im_gnt_i),
        .im_rvalid_i   (im_rvalid_i),
        .im_rdata_i    (im_rdata_i),
        .id_pc_o       (id_pc_o),
        .id_inst_o     (id_inst_o),
        .id_valid_o    (id_valid_o),
`ifdef IF_PERF_EN
        .if_wait_o     (if_wait_o),
        .perf_fetch_o  (perf_fetch_o),
        .perf_kill_o   (perf_kill_o)
`else
        .if_wait_o     (if_wait_o)
`endif
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return 32'h0010_0093 ^ (a << 12);
    endfunction

    // Memory: grant unless blocked, data rv_lat cycles after grant
    int          gnt_block = 0;
    int          rv_lat = 1;
    int          pend = 0;
    logic [31:0] pend_addr = '0;

    initial begin
        logic        req_acc;
        logic        rv_acc;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            req_acc = im_req_o && im_gnt_i;
            rv_acc  = im_rvalid_i;
            a       = im_addr_o;
            @(posedge clk);
            #1;
            if (rv_acc) im_rvalid_i = 1'b0;
            if (req_acc) begin
                pend      = rv_lat;
                pend_addr = a;
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    im_rvalid_i = 1'b1;
                    im_rdata_i  = inst_of(pend_addr);
                end
            end
            if (gnt_block > 0) begin
                im_gnt_i = 1'b0;
                gnt_block--;
            end else begin
                im_gnt_i = 1'b1;
            end
        end
    end

    // Program-order model: next fetch address, next delivered pc
    logic [31:0] exp_fetch;
    logic [31:0] exp_del;
    logic        outst;
    logic        killed;
    logic        prev_hold_req;
    logic        prev_redir;
    logic [31:0] prev_addr;
    int          m_fetch;
    int          m_kill;
    logic [31:0] gq[$];

    always @(negedge clk) begin
        if (!rstn) begin
            exp_fetch     = 32'h0;
            exp_del       = 32'h0;
            outst         = 1'b0;
            killed        = 1'b0;
            prev_hold_req = 1'b0;
            prev_redir    = 1'b0;
            prev_addr     = '0;
            m_fetch       = 0;
            m_kill        = 0;
        end else begin
            if (prev_hold_req) begin
                check("req_stable", im_req_o, 1'b1);
                check("addr_stable", im_addr_o, prev_addr);
            end
            if (prev_redir) begin
                check("bubble_valid", id_valid_o, 1'b0);
                check("bubble_inst", id_inst_o, 32'h0);
            end
            if (id_valid_o) begin
                check("id_pc", id_pc_o, exp_del);
                check("id_inst", id_inst_o, inst_of(id_pc_o));
            end
            check("if_wait", if_wait_o, outst && !im_rvalid_i);
`ifdef IF_PERF_EN
            check("perf_fetch", perf_fetch_o, m_fetch);
            check("perf_kill", perf_kill_o, m_kill);
`endif
            if (im_rvalid_i && outst) begin
                outst = 1'b0;
                if (killed || redirect_i) m_kill++;
                else m_fetch++;
                killed = 1'b0;
            end
            if (im_req_o && im_gnt_i) begin
                check("fetch_addr", im_addr_o, exp_fetch);
                gq.push_back(im_addr_o);
                exp_fetch = exp_fetch + 32'd4;
                outst     = 1'b1;
                killed    = 1'b0;
            end
            if (redirect_i) begin
                if (outst) killed = 1'b1;
                exp_fetch = redirect_pc_i;
                exp_del   = redirect_pc_i;
            end else if (id_valid_o && !stall_i) begin
                exp_del = exp_del + 32'd4;
            end
            prev_hold_req = im_req_o && !im_gnt_i && !redirect_i;
            prev_addr     = im_addr_o;
            prev_redir    = redirect_i;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req"}, im_req_o, 1'b0);
        check({tag, "_addr"}, im_addr_o, 32'h0);
        check({tag, "_valid"}, id_valid_o, 1'b0);
        check({tag, "_pc"}, id_pc_o, 32'h0);
        check({tag, "_inst"}, id_inst_o, 32'h0);
        check({tag, "_wait"}, if_wait_o, 1'b0);
`ifdef IF_PERF_EN
        check({tag, "_pf"}, perf_fetch_o, 32'h0);
        check({tag, "_pk"}, perf_kill_o, 32'h0);
`endif
    endtask

    initial begin
        step(2);
        check_reset("rst");

        // Boot and first fetch
        rstn = 1'b1;
        step(3);
        check("t1_valid", id_valid_o, 1'b1);
        check("t1_pc", id_pc_o, 32'h0);
        check("t1_inst", id_inst_o, 32'h0010_0093);

        // Stall absorbed by skid buffer
        stall_i = 1'b1;
        step(3);
        check("t2_valid", id_valid_o, 1'b1);
        check("t2_pc", id_pc_o, 32'h0);
        check("t2_noreq", im_req_o, 1'b0);
        stall_i = 1'b0;
        step(1);
        check("t2_pc4", id_pc_o, 32'h4);
        check("t2_valid4", id_valid_o, 1'b1);
        check("t2_req", im_req_o, 1'b1);
        check("t2_addr8", im_addr_o, 32'h8);

        // Redirect while waiting; late data dropped
        rv_lat = 3;
        step(1);
        check("t3_wait", if_wait_o, 1'b1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        step(1);
        redirect_i = 1'b0;
        rv_lat     = 1;
        step(2);
        check("t3_valid", id_valid_o, 1'b0);
        check("t3_inst", id_inst_o, 32'h0);
        check("t3_req", im_req_o, 1'b1);
        check("t3_addr", im_addr_o, 32'h100);
`ifdef IF_PERF_EN
        check("t3_pk", perf_kill_o, 32'd1);
`endif
        check("gq_size", (gq.size() >= 3), 1'b1);
        if (gq.size() >= 3) begin
            check("gq0", gq[0], 32'h0);
            check("gq1", gq[1], 32'h4);
            check("gq2", gq[2], 32'h8);
        end

        // Redirect + stall + rvalid together
        step(1);
        stall_i       = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step(1);
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        check("t4_valid", id_valid_o, 1'b0);
        check("t4_inst", id_inst_o, 32'h0);
        check("t4_req", im_req_o, 1'b1);
        check("t4_addr", im_addr_o, 32'h200);
`ifdef IF_PERF_EN
        check("t4_pk", perf_kill_o, 32'd2);
`endif

        // Grant withheld for 5 cycles
        gnt_block = 4;
        im_gnt_i  = 1'b0;
        step(2);
        check("t5_req", im_req_o, 1'b1);
        check("t5_addr", im_addr_o, 32'h200);
        check("t5_wait", if_wait_o, 1'b0);
        step(3);
        check("t5_req_late", im_req_o, 1'b1);
        check("t5_wait_late", if_wait_o, 1'b0);
        step(2);
        check("t5_valid", id_valid_o, 1'b1);
        check("t5_pc", id_pc_o, 32'h200);

        // Redirect on grant cycle, then PC wrap
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step(1);
        redirect_i = 1'b0;
        step(3);
        check("t6_valid", id_valid_o, 1'b1);
        check("t6_pc", id_pc_o, 32'hFFFF_FFFC);
        check("t6_addr", im_addr_o, 32'h0);

        // Reset mid-fetch, late rvalid ignored
        rv_lat = 3;
        step(1);
        rstn = 1'b0;
        #1;
        check_reset("mid");
        step(1);
        rstn   = 1'b1;
        rv_lat = 1;
        step(3);
        check("t7_valid", id_valid_o, 1'b1);
        check("t7_pc", id_pc_o, 32'h0);
        check("t7_inst", id_inst_o, 32'h0010_0093);
        check("t7_addr", im_addr_o, 32'h4);
`ifdef IF_PERF_EN
        check("t7_pf", perf_fetch_o, 32'd1);
        check("t7_pk", perf_kill_o, 32'd0);
`endif

        step(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
